// File: rtl/fb_pkg.sv
// Shared framebuffer types: geometry constants, queued write entry, arbiter states.
package fb_pkg;
  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 24;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } fb_wr_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/fb_access_arbiter_if.sv
// Framebuffer arbiter bus: scanout reads, buffered writes, RAM port and frame-lock status.
// master = requesters plus RAM side, slave = the arbiter.
interface fb_access_arbiter_if #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int WFIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(WFIFO_DEPTH + 1);

  logic              vblank;
  logic              frame_lock;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  wfifo_level;
  logic              locked;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output vblank, frame_lock, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_valid, rd_data, wr_ready, wfifo_level, locked, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  vblank, frame_lock, rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_valid, rd_data, wr_ready, wfifo_level, locked, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/wr_fifo.sv
// Synchronous write-queue FIFO of fb_wr_t; head is visible combinationally, push/pop take effect at the edge.
// Caller never pushes when full nor pops when empty.
module wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  fb_wr_t           push_dat,
  input  logic             pop,
  output fb_wr_t           head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  fb_wr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: scanout reads always win (2-cycle read latency); writes queue and issue in idle slots.
// wr_ready drops only when the write queue is full; frame-lock confines writes to vblank.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = PIX_W,
  parameter int WFIFO_DEPTH = 4
) (
  input logic                clk_25,
  input logic                n_rst,
  fb_access_arbiter_if.slave bus
);
  localparam int LVL_W = $clog2(WFIFO_DEPTH + 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             vblank_q;
  logic             vblank_rise;
  logic             write_allow;
  logic [1:0]       rd_pipe;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  fb_wr_t           push_dat;
  fb_wr_t           head;
  logic [LVL_W-1:0] level;

  assign vblank_rise = bus.vblank && !vblank_q;
  assign write_allow = (state == OPEN) || bus.vblank;
  assign push        = bus.wr_valid && !full;
  // A pending read always takes the slot; the write simply waits.
  assign pop         = !bus.rd_req && !empty && write_allow;

  assign push_dat.addr = FB_ADDR_W'(bus.wr_addr);
  assign push_dat.data = PIX_W'(bus.wr_data);

  wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_wr_fifo (
    .clk      (clk_25),
    .n_rst    (n_rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // frame_lock only matters at the vblank rising edge.
  always_comb begin
    state_nxt = state;
    if (vblank_rise) begin
      case (state)
        OPEN:    if (bus.frame_lock)  state_nxt = LOCKED;
        LOCKED:  if (!bus.frame_lock) state_nxt = OPEN;
        default: state_nxt = OPEN;
      endcase
    end
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      state    <= OPEN;
      vblank_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      vblank_q <= bus.vblank;
    end
  end

  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      rd_pipe       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      rd_pipe    <= {rd_pipe[0], bus.rd_req};
      bus.mem_we <= pop;
      if (bus.rd_req) begin
        bus.mem_addr <= bus.rd_addr;
      end else if (pop) begin
        bus.mem_addr  <= ADDR_W'(head.addr);
        bus.mem_wdata <= DATA_W'(head.data);
      end
    end
  end

  assign bus.rd_valid    = rd_pipe[1];
  assign bus.rd_data     = bus.mem_rdata;
  assign bus.wr_ready    = !full;
  assign bus.wfifo_level = level;
  assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the arbitration rules.
module tb_fb_access_arbiter;
  import fb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 24;
  localparam int D  = 4;

  logic clk_25 = 1'b0;
  logic n_rst  = 1'b0;
  always #20 clk_25 = ~clk_25;

  fb_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(D)) bus ();

  fb_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(D)) dut (
    .clk_25 (clk_25),
    .n_rst  (n_rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
    return DW'(a) + 24'h100;
  endfunction

  // RAM: one-cycle read latency, contents are a fixed function of the address.
  always @(posedge clk_25) bus.mem_rdata <= ram_word(bus.mem_addr);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending writes, lock flag, and what the outputs must show after the last edge.
  fb_wr_t        mq[$];
  bit            m_lock, m_vbq;
  bit            e_rst, e_issue, e_rdv, e_we;
  logic [AW-1:0] e_issue_addr;
  logic [DW-1:0] e_rdata;
  fb_wr_t        e_wr;

  always @(posedge clk_25) begin
    bit     do_pop, do_push;
    fb_wr_t w;
    if (!n_rst) begin
      mq.delete();
      m_lock  = 1'b0;
      m_vbq   = 1'b0;
      e_rst   = 1'b1;
      e_issue = 1'b0;
      e_rdv   = 1'b0;
      e_we    = 1'b0;
    end else begin
      e_rst   = 1'b0;
      e_rdv   = e_issue;
      e_rdata = ram_word(e_issue_addr);
      do_pop  = !bus.rd_req && mq.size() > 0 && (!m_lock || bus.vblank);
      do_push = bus.wr_valid && mq.size() < D;
      e_issue      = bus.rd_req;
      e_issue_addr = bus.rd_addr;
      e_we         = do_pop;
      if (do_pop) e_wr = mq.pop_front();
      if (do_push) begin
        w.addr = bus.wr_addr;
        w.data = bus.wr_data;
        mq.push_back(w);
      end
      if (bus.vblank && !m_vbq) m_lock = bus.frame_lock;
      m_vbq = bus.vblank;
    end
  end

  always @(negedge clk_25) begin
    if (chk_en) begin
      chk("mem_we", 32'(bus.mem_we), 32'(e_we));
      if (e_we) begin
        chk("wr_addr_out", 32'(bus.mem_addr), 32'(e_wr.addr));
        chk("wr_data_out", 32'(bus.mem_wdata), 32'(e_wr.data));
      end else if (e_issue) begin
        chk("rd_addr_out", 32'(bus.mem_addr), 32'(e_issue_addr));
      end
      if (e_rst) begin
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
      end
      chk("rd_valid", 32'(bus.rd_valid), 32'(e_rdv));
      if (e_rdv) chk("rd_data", 32'(bus.rd_data), 32'(e_rdata));
      chk("level", 32'(bus.wfifo_level), 32'(mq.size()));
      chk("wr_ready", 32'(bus.wr_ready), 32'(mq.size() < D));
      chk("locked", 32'(bus.locked), 32'(m_lock));
    end
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  logic [AW-1:0] exp_a[4];
  logic [DW-1:0] exp_d[4];

  initial begin
    bus.vblank = 0; bus.frame_lock = 0; bus.rd_req = 0; bus.rd_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    n_rst = 0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_level", 32'(bus.wfifo_level), 32'd0);
    chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    n_rst = 1;
    tick();

    // Back-to-back reads, addresses 0..9.
    for (int i = 0; i < 12; i++) begin
      bus.rd_req  = (i < 10);
      bus.rd_addr = AW'(i);
      tick();
      if (i == 0) chk("rd_first_not_valid", 32'(bus.rd_valid), 32'd0);
      if (i >= 1 && i <= 10) begin
        chk("rd_seq_valid", 32'(bus.rd_valid), 32'd1);
        chk("rd_seq_data", 32'(bus.rd_data), 32'h100 + 32'(i - 1));
      end
    end
    bus.rd_req = 0;

    // Single idle write reaches the RAM two cycles after the push.
    bus.wr_valid = 1; bus.wr_addr = 19'h12C00; bus.wr_data = 24'hFF0000;
    tick();
    bus.wr_valid = 0;
    chk("idle_wr_level1", 32'(bus.wfifo_level), 32'd1);
    chk("idle_wr_not_yet", 32'(bus.mem_we), 32'd0);
    tick();
    chk("idle_wr_we", 32'(bus.mem_we), 32'd1);
    chk("idle_wr_addr", 32'(bus.mem_addr), 32'h12C00);
    chk("idle_wr_data", 32'(bus.mem_wdata), 32'hFF0000);
    chk("idle_wr_level0", 32'(bus.wfifo_level), 32'd0);

    // Reads collide with three queued writes.
    for (int i = 0; i < 10; i++) begin
      bus.rd_req   = 1;
      bus.rd_addr  = AW'(32'h40 + i);
      bus.wr_valid = (i < 3);
      bus.wr_addr  = AW'(32'h500 + i);
      bus.wr_data  = DW'(32'hA0000 + i);
      tick();
      chk("coll_no_we", 32'(bus.mem_we), 32'd0);
    end
    bus.rd_req = 0; bus.wr_valid = 0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("coll_we", 32'(bus.mem_we), 32'd1);
      chk("coll_addr", 32'(bus.mem_addr), 32'h500 + 32'(j));
    end
    tick();
    chk("coll_done", 32'(bus.mem_we), 32'd0);

    // Lock at vblank rise, fill the FIFO outside vblank.
    bus.frame_lock = 1; bus.vblank = 1;
    tick();
    chk("lock_set", 32'(bus.locked), 32'd1);
    bus.vblank = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.wr_valid = 1;
      bus.wr_addr  = AW'(32'h7000 + i);
      bus.wr_data  = DW'(32'h330000 + i);
      if (i < 4) begin
        exp_a[i] = bus.wr_addr;
        exp_d[i] = bus.wr_data;
      end
      tick();
      chk("full_level", 32'(bus.wfifo_level), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("full_ready", 32'(bus.wr_ready), 32'(i < 3));
      chk("full_no_we", 32'(bus.mem_we), 32'd0);
    end
    bus.wr_valid = 0; bus.vblank = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("drain_we", 32'(bus.mem_we), 32'd1);
      chk("drain_addr", 32'(bus.mem_addr), 32'(exp_a[j]));
      chk("drain_data", 32'(bus.mem_wdata), 32'(exp_d[j]));
      chk("drain_ready", 32'(bus.wr_ready), 32'd1);
    end

    // frame_lock changes mid-frame are ignored until the next vblank rise.
    bus.vblank = 0;
    tick();
    bus.frame_lock = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lock_hold", 32'(bus.locked), 32'd1);
    end
    bus.vblank = 1;
    tick();
    chk("lock_release", 32'(bus.locked), 32'd0);
    bus.frame_lock = 1;
    tick();
    chk("lock_no_rise", 32'(bus.locked), 32'd0);
    bus.vblank = 0;
    tick();
    chk("lock_no_rise2", 32'(bus.locked), 32'd0);
    bus.vblank = 1;
    tick();
    chk("lock_relock", 32'(bus.locked), 32'd1);

    // Reset with queued writes and reads in flight.
    bus.vblank = 0;
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1; bus.rd_addr = AW'(32'h90 + i);
      bus.wr_valid = 1; bus.wr_addr = AW'(32'h6660 + i); bus.wr_data = DW'(32'h123400 + i);
      tick();
    end
    bus.wr_valid = 0;
    chk("pre_rst_level", 32'(bus.wfifo_level), 32'd3);
    n_rst = 0;
    tick();
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_rdv", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_level", 32'(bus.wfifo_level), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
    n_rst = 1; bus.rd_req = 0; bus.vblank = 1; bus.frame_lock = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_we", 32'(bus.mem_we), 32'd0);
    end

    // Random traffic against the model.
    begin
      int vb_left = 30;
      for (int c = 0; c < 4000; c++) begin
        if (vb_left == 0) begin
          bus.vblank = !bus.vblank;
          vb_left = bus.vblank ? $urandom_range(8, 30) : $urandom_range(20, 80);
        end else begin
          vb_left--;
        end
        if ($urandom_range(0, 29) == 0) bus.frame_lock = !bus.frame_lock;
        bus.rd_req   = bus.vblank ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
        bus.rd_addr  = AW'($urandom);
        bus.wr_valid = $urandom_range(0, 1) == 1;
        bus.wr_addr  = AW'($urandom);
        bus.wr_data  = DW'($urandom);
        n_rst        = ($urandom_range(0, 699) != 0);
        tick();
      end
    end
    n_rst = 1;
    tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
